// File: rtl/sd_dac_pkg.sv
// -----------------------------------------------------------------------------
// sd_dac_pkg
// Shared constants and helpers for the multi-channel sigma-delta DAC:
//   - dither LFSR tap mask, seed and next-state function
//   - legal modulator orders
//   - clamp limit of the second-order loop input
// No ports (package).
// -----------------------------------------------------------------------------
package sd_dac_pkg;

    // Dither LFSR: 16-bit Fibonacci, taps 16,14,13,11 (bits 15,13,12,10).
    localparam int unsigned LFSR_W    = 32'd16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Legal modulator orders.
    typedef enum int {
        ORD_1 = 32'sd1,
        ORD_2 = 32'sd2
    } order_e;

    // Shift left, feed back the XOR of the tapped bits into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Second-order loop input limit: 2^(bw-1) - 2^(bw-3) keeps the
    // integrators bounded well inside their widths.
    function automatic int clamp_lim(input int bw);
        return (32'sd1 <<< (bw - 32'sd1)) - (32'sd1 <<< (bw - 32'sd3));
    endfunction

endpackage

// File: rtl/sd_mod_ch.sv
// -----------------------------------------------------------------------------
// sd_mod_ch
// One channel of the sigma-delta modulator (order 1 or 2, chosen by ORDER).
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - asynchronous active-high reset
//   en_i    - modulation enable; state cleared and output 0 while low
//   smp_i   - active signed sample (BW bits)
//   dith_i  - +1 LSB dither added to the sample before the first integrator
//   dac_o   - registered 1-bit modulator output
// -----------------------------------------------------------------------------
module sd_mod_ch
    import sd_dac_pkg::*;
#(
    parameter int BW    = 14,
    parameter int ORDER = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [BW-1:0] smp_i,
    input  logic          dith_i,
    output logic          dac_o
);

    logic dac_r;

    assign dac_o = dac_r;

    generate
        if (ORDER == ORD_2) begin : g_order2
            localparam int W1 = BW + 2;
            localparam int W2 = BW + 4;
            localparam logic signed [BW-1:0] LIM_P = BW'(clamp_lim(BW));
            localparam logic signed [BW-1:0] LIM_N = -LIM_P;
            // Feedback magnitude 2^(BW-1) at each integrator width.
            localparam logic signed [W1-1:0] FB1 = {2'b00, 1'b1, {(BW-1){1'b0}}};
            localparam logic signed [W2-1:0] FB2 = {4'b0000, 1'b1, {(BW-1){1'b0}}};

            logic signed [BW-1:0] x_s;
            logic signed [BW-1:0] x_cl_s;
            logic signed [W1-1:0] xd_s;
            logic signed [W1-1:0] fb1_s;
            logic signed [W1-1:0] i1_r;
            logic signed [W1-1:0] i1_nxt_s;
            logic signed [W2-1:0] fb2_s;
            logic signed [W2-1:0] i2_r;
            logic signed [W2-1:0] i2_nxt_s;

            // Clamp the sample, add dither and compute both integrator updates.
            always_comb begin
                x_s = $signed(smp_i);
                if (x_s > LIM_P) begin
                    x_cl_s = LIM_P;
                end else if (x_s < LIM_N) begin
                    x_cl_s = LIM_N;
                end else begin
                    x_cl_s = x_s;
                end
                xd_s = W1'(x_cl_s) + $signed({{(W1-1){1'b0}}, dith_i});
                if (dac_r) begin
                    fb1_s = FB1;
                    fb2_s = FB2;
                end else begin
                    fb1_s = -FB1;
                    fb2_s = -FB2;
                end
                i1_nxt_s = i1_r + xd_s - fb1_s;
                i2_nxt_s = i2_r + W2'(i1_nxt_s) - fb2_s;
            end

            // Integrator state and comparator output; cleared while disabled.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    i1_r  <= '0;
                    i2_r  <= '0;
                    dac_r <= 1'b0;
                end else if (!en_i) begin
                    i1_r  <= '0;
                    i2_r  <= '0;
                    dac_r <= 1'b0;
                end else begin
                    i1_r  <= i1_nxt_s;
                    i2_r  <= i2_nxt_s;
                    dac_r <= ~i2_nxt_s[W2-1];
                end
            end
        end else begin : g_order1
            localparam logic [BW-1:0] MSB_MASK = {1'b1, {(BW-1){1'b0}}};

            logic [BW-1:0] acc_r;
            logic [BW:0]   sum_s;

            // Offset-binary sample (sign bit flipped) plus dither into the accumulator.
            always_comb begin
                sum_s = {1'b0, acc_r} + {1'b0, smp_i ^ MSB_MASK} + {{BW{1'b0}}, dith_i};
            end

            // Accumulator; its carry out is the output bit. Cleared while disabled.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    acc_r <= '0;
                    dac_r <= 1'b0;
                end else if (!en_i) begin
                    acc_r <= '0;
                    dac_r <= 1'b0;
                end else begin
                    acc_r <= sum_s[BW-1:0];
                    dac_r <= sum_s[BW];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sd_dac_mc.sv
// -----------------------------------------------------------------------------
// sd_dac_mc
// Multi-channel sigma-delta DAC with a one-deep pending sample buffer that is
// transferred to the active register once per OSR-cycle frame.
// Optional feature: define SD_DAC_DITHER_EN to add LFSR dither (+1 LSB,
// channel k uses LFSR bit k mod 16). Without it no LFSR is built.
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - asynchronous active-high reset
//   en_i         - modulation enable (frame counter and modulators)
//   smp_valid_i  - sample vector valid
//   smp_ready_o  - pending buffer free
//   smp_i        - CH signed samples, channel k at [k*BW +: BW]
//   dac_o        - registered 1-bit output per channel
//   frame_o      - one-cycle pulse following each frame wrap
//   underrun_o   - one-cycle pulse with frame_o when the wrap found no sample
// -----------------------------------------------------------------------------
module sd_dac_mc
    import sd_dac_pkg::*;
#(
    parameter int BW    = 14,
    parameter int CH    = 2,
    parameter int OSR   = 64,
    parameter int ORDER = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             smp_valid_i,
    output logic             smp_ready_o,
    input  logic [CH*BW-1:0] smp_i,
    output logic [CH-1:0]    dac_o,
    output logic             frame_o,
    output logic             underrun_o
);

    localparam int            CW      = $clog2(OSR);
    localparam logic [CW-1:0] CNT_MAX = CW'(OSR - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0]    cnt_r;
    logic [CH*BW-1:0] pend_r;
    logic [CH*BW-1:0] act_r;
    logic             pend_full_r;
    logic             frame_r;
    logic             underrun_r;
    logic             wrap_s;
    logic             accept_s;
    logic [CH-1:0]    dith_s;
    logic [CH-1:0]    dac_s;

    assign smp_ready_o = ~pend_full_r;
    assign frame_o     = frame_r;
    assign underrun_o  = underrun_r;
    assign dac_o       = dac_s;

    // Frame wrap and sample handshake decode.
    always_comb begin
        wrap_s   = en_i & (cnt_r == CNT_MAX);
        accept_s = smp_valid_i & ~pend_full_r;
    end

    // Frame counter: counts through one frame while enabled, parked at 0 otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (!en_i || wrap_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Sample buffers: a wrap with a full buffer transfers; otherwise an accept
    // fills pending (including on an empty-buffer wrap, which then underruns).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_r      <= '0;
            act_r       <= '0;
            pend_full_r <= 1'b0;
        end else if (wrap_s && pend_full_r) begin
            act_r       <= pend_r;
            pend_full_r <= 1'b0;
        end else if (accept_s) begin
            pend_r      <= smp_i;
            pend_full_r <= 1'b1;
        end else begin
            pend_full_r <= pend_full_r;
        end
    end

    // Frame and underrun strobes, registered from the wrap cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_r    <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            frame_r    <= wrap_s;
            underrun_r <= wrap_s & ~pend_full_r;
        end
    end

`ifdef SD_DAC_DITHER_EN
    logic [LFSR_W-1:0] lfsr_r;

    // Dither LFSR; advances only while modulating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_r <= LFSR_SEED;
        end else if (en_i) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Channel k takes LFSR bit k mod 16.
    always_comb begin
        dith_s = '0;
        for (int k = 0; k < CH; k++) begin
            dith_s[k] = lfsr_r[k % LFSR_W];
        end
    end
`else
    assign dith_s = {CH{1'b0}};
`endif

    for (genvar k = 0; k < CH; k++) begin : g_ch
        sd_mod_ch #(
            .BW    (BW),
            .ORDER (ORDER)
        ) u_mod (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (en_i),
            .smp_i  (act_r[k*BW +: BW]),
            .dith_i (dith_s[k]),
            .dac_o  (dac_s[k])
        );
    end

endmodule

// File: tb/tb_sd_dac_mc.sv
// -----------------------------------------------------------------------------
// tb_sd_dac_mc
// Drives an ORDER=1 and an ORDER=2 instance with identical stimulus and checks
// both against an integer reference model every cycle, plus literal
// expectations for output densities, underrun and reset timing.
// -----------------------------------------------------------------------------
module tb_sd_dac_mc;

    localparam int BW   = 14;
    localparam int CH   = 2;
    localparam int OSR  = 64;
    localparam int HALF = 1 << (BW - 1);
    localparam int FULL = 1 << BW;
    localparam int LIM  = HALF - (1 << (BW - 3));

    logic             clk;
    logic             rst;
    logic             en;
    logic             vld;
    logic [CH*BW-1:0] smp;
    logic             rdy1, rdy2;
    logic [CH-1:0]    dac1, dac2;
    logic             frm1, frm2;
    logic             und1, und2;

    sd_dac_mc #(.BW(BW), .CH(CH), .OSR(OSR), .ORDER(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .smp_valid_i(vld), .smp_ready_o(rdy1),
        .smp_i(smp), .dac_o(dac1), .frame_o(frm1), .underrun_o(und1));

    sd_dac_mc #(.BW(BW), .CH(CH), .OSR(OSR), .ORDER(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .smp_valid_i(vld), .smp_ready_o(rdy2),
        .smp_i(smp), .dac_o(dac2), .frame_o(frm2), .underrun_o(und2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_checks = 0;

    // reference model state
    int m_cnt, m_full, m_frame, m_under;
    int m_pend[CH], m_act[CH], m_acc[CH], m_d1[CH], m_i1[CH], m_i2[CH], m_d2[CH];
    int max_i1, max_i2;

    // measurement counters
    bit counting;
    int ones1[CH], ones2[CH];
    int und_cnt, rdy_low;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [CH*BW-1:0] pack(input int a, input int b);
        logic [BW-1:0] la, lb;
        la = BW'(a);
        lb = BW'(b);
        return {lb, la};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_full = 0; m_frame = 0; m_under = 0;
        for (int c = 0; c < CH; c++) begin
            m_pend[c] = 0; m_act[c] = 0; m_acc[c] = 0; m_d1[c] = 0;
            m_i1[c] = 0; m_i2[c] = 0; m_d2[c] = 0;
        end
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step();
        bit wrap, take;
        int u, s, x, xc, fb;
        logic [BW-1:0] raw;
        wrap = en && (m_cnt == OSR - 1);
        take = vld && (m_full == 0);
        for (int c = 0; c < CH; c++) begin
            if (!en) begin
                m_acc[c] = 0; m_d1[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_d2[c] = 0;
            end else begin
                // first order: offset-binary phase accumulator, output = overflow
                u = m_act[c] + HALF;
                s = m_acc[c] + u;
                m_d1[c] = (s >= FULL);
                m_acc[c] = s % FULL;
                // second order: clamped input, +/-HALF feedback to both integrators
                x = m_act[c];
                xc = (x > LIM) ? LIM : ((x < -LIM) ? -LIM : x);
                fb = m_d2[c] ? HALF : -HALF;
                m_i1[c] = m_i1[c] + xc - fb;
                m_i2[c] = m_i2[c] + m_i1[c] - fb;
                m_d2[c] = (m_i2[c] >= 0);
                if (iabs(m_i1[c]) > max_i1) max_i1 = iabs(m_i1[c]);
                if (iabs(m_i2[c]) > max_i2) max_i2 = iabs(m_i2[c]);
            end
        end
        m_frame = wrap;
        m_under = wrap && (m_full == 0);
        if (wrap && m_full) begin
            for (int c = 0; c < CH; c++) m_act[c] = m_pend[c];
            m_full = 0;
        end else if (take) begin
            for (int c = 0; c < CH; c++) begin
                raw = smp[c*BW +: BW];
                m_pend[c] = int'($signed(raw));
            end
            m_full = 1;
        end
        m_cnt = en ? (wrap ? 0 : m_cnt + 1) : 0;
    endtask

    task automatic compare_all();
        chk("ready1", rdy1, (m_full == 0));
        chk("ready2", rdy2, (m_full == 0));
        chk("frame1", frm1, m_frame);
        chk("frame2", frm2, m_frame);
        chk("underrun1", und1, m_under);
        chk("underrun2", und2, m_under);
        for (int c = 0; c < CH; c++) begin
            chk("dac1", dac1[c], m_d1[c]);
            chk("dac2", dac2[c], m_d2[c]);
        end
    endtask

    // Advance one clock: model follows the edge, outputs compared at negedge.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        compare_all();
        if (counting) begin
            for (int c = 0; c < CH; c++) begin
                ones1[c] += dac1[c];
                ones2[c] += dac2[c];
            end
        end
        und_cnt += und1;
        if (!rdy1) rdy_low++;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) begin
            ones1[c] = 0;
            ones2[c] = 0;
        end
        und_cnt = 0;
        rdy_low = 0;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_ready1", rdy1, 1);
        chk("rst_ready2", rdy2, 1);
        chk("rst_dac1", dac1, 0);
        chk("rst_dac2", dac2, 0);
        chk("rst_underrun1", und1, 0);
        chk("rst_frame1", frm1, 0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0; en = 1'b0; vld = 1'b0; smp = '0;
        counting = 1'b0;
        max_i1 = 0; max_i2 = 0;
        model_reset();
        clear_counts();
        #1 rst = 1'b1;
        #1;
        compare_all();
        chk("init_ready", rdy1, 1);
        chk("init_dac2", dac2, 0);
        repeat (3) cycle();
        rst = 1'b0;

        // zero input, one sample per frame: half density
        en = 1'b1; vld = 1'b1; smp = pack(0, 0);
        clear_counts(); counting = 1'b1;
        repeat (1024) cycle();
        counting = 1'b0;
        chk_range("zero_ones_ch0", ones1[0], 511, 513);
        chk_range("zero_ones_ch1", ones1[1], 511, 513);

        // +4096: three-quarter density on the first-order modulator
        smp = pack(4096, 4096);
        repeat (200) cycle();
        clear_counts(); counting = 1'b1;
        repeat (4096) cycle();
        counting = 1'b0;
        chk_range("p4096_ones_ch0", ones1[0], 3071, 3073);
        chk_range("p4096_ones_ch1", ones1[1], 3071, 3073);

        // second order with out-of-range inputs clamped to +/-6144
        smp = pack(-8191, 8191);
        repeat (200) cycle();
        max_i1 = 0; max_i2 = 0;
        clear_counts(); counting = 1'b1;
        repeat (8192) cycle();
        counting = 1'b0;
        chk_range("m8191_ones_ch0", ones2[0], 942, 1106);
        chk_range("p8191_ones_ch1", ones2[1], 7086, 7250);
        chk("i1_in_range", (max_i1 < (1 << (BW + 1))), 1);
        chk("i2_in_range", (max_i2 < (1 << (BW + 3))), 1);

        // one frame without a sample; new sample offered exactly on the wrap
        smp = pack(100, -100);
        n = 0;
        do begin cycle(); n++; end while (!frm1 && n < 200);
        chk("frame_seen", frm1, 1);
        clear_counts();
        vld = 1'b0;
        repeat (OSR - 1) cycle();
        chk("gap_ready_low_cycles", rdy_low, 0);
        smp = pack(-300, 300);
        vld = 1'b1;
        cycle();
        chk("underrun_pulse", und1, 1);
        chk("underrun_with_frame", frm1, 1);
        chk("underrun_dut2", und2, 1);
        chk("wrap_accept_ready", rdy1, 0);
        repeat (70) cycle();
        chk("underrun_count", und_cnt, 1);

        // reset mid-frame with a full pending buffer
        n = 0;
        do begin cycle(); n++; end while (!(m_cnt == 30 && m_full == 1) && n < 200);
        chk("cnt30_reached", (m_cnt == 30 && m_full == 1), 1);
        pulse_reset();
        n = 0;
        do begin cycle(); n++; end while (!frm1 && n < 200);
        chk("frame_after_release", n, OSR);

        // randomized traffic, enable toggling and occasional resets
        for (int i = 0; i < 4000; i++) begin
            vld = ($urandom_range(0, 99) < 70);
            smp = (CH*BW)'($urandom());
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 1499) == 0) pulse_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sd_dac_mc.md
SD_DAC_MC -- requirements
Module: sd_dac_mc

Interface
REQ-001 SHALL have parameter BW, default 14: signed sample width per channel.
REQ-002 SHALL have parameter CH, default 2: number of independent channels.
REQ-003 SHALL have parameter OSR, default 64: clock cycles per sample frame, power of two, range 4..1024.
REQ-004 SHALL have parameter ORDER, default 1: modulator order, legal values 1 or 2.
REQ-005 SHALL have port clk_i, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port en_i, input, 1: modulation enable.
REQ-008 SHALL have port smp_valid_i, input, 1: sample vector valid.
REQ-009 SHALL have port smp_ready_o, output, 1: pending buffer free.
REQ-010 SHALL have port smp_i, input, CH*BW: signed samples; channel k occupies bits [k*BW +: BW].
REQ-011 SHALL have port dac_o, output, CH: 1-bit modulator output per channel, registered.
REQ-012 SHALL have port frame_o, output, 1: one-cycle pulse on the frame-wrap cycle.
REQ-013 SHALL have port underrun_o, output, 1: one-cycle pulse on a wrap with an empty pending buffer.

Function
REQ-014 SHALL run frame counter cnt from 0 to OSR-1 while en_i=1; wrap = (cnt==OSR-1); the counter holds at 0 while en_i=0.
REQ-015 SHALL accept smp_i into the pending register when smp_valid_i && smp_ready_o; smp_ready_o = !pend_full, independent of en_i.
REQ-016 SHALL, on wrap with pend_full=1, copy pending to active and clear pend_full; the new active value first affects dac_o on the following cycle.
REQ-017 SHALL, on wrap with pend_full=0, keep the active value, pulse underrun_o, and raise frame_o in the same cycle.
REQ-018 SHALL treat an accept in a wrap cycle (buffer empty) as: the sample lands in pending, the wrap reports underrun, and transfer occurs at the next wrap.
REQ-019 SHALL, with ORDER=1, use a BW-bit accumulator per channel: acc' = acc + (x XOR MSB-mask), with x converted to offset binary; dac_o = carry out.
REQ-020 SHALL, with ORDER=2, clamp x to ±(2^(BW-1) - 2^(BW-3)) and use the CIFB loop: fb = dac_o ? +2^(BW-1) : -2^(BW-1); i1' = i1 + x - fb (BW+2 bits); i2' = i2 + i1' - fb (BW+4 bits); dac_o' = (i2' >= 0).
REQ-021 SHALL, while en_i=0, clear the integrators/accumulators and drive dac_o=0, frame_o=0 and underrun_o=0.
REQ-022 SHALL process channels in parallel, with identical timing and no cross-channel interaction.

Reset
REQ-023 SHALL, with rst_i=1, force dac_o=0, frame_o=0, underrun_o=0, smp_ready_o=1, cnt=0, pending=active=0, pend_full=0 and all integrators to 0, immediately and without a clock.
REQ-024 SHALL discard any pending sample and any partial frame when reset is asserted mid-frame, and restart at cnt=0 on the first edge after release.

Configuration
REQ-025 SHALL, when SD_DAC_DITHER_EN is defined, add a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; advances every cycle while en_i=1); channel k adds LFSR bit k mod 16 as a +1 LSB to x before the first integrator.
REQ-026 SHALL, when SD_DAC_DITHER_EN is undefined, contain no LFSR, and the output SHALL be bit-exact to REQ-019/REQ-020.

Structure
REQ-027 SHALL place the LFSR taps and seed, the ORDER legal values, and the clamp-limit constant function in package sd_dac_pkg.
REQ-028 SHALL implement one channel's modulator as sub-module sd_mod_ch (ports: clock, reset, enable, active sample, dither bit, dac bit), instantiated CH times.

Verification
REQ-029 SHALL cover: rst_i=1 asserted between edges -> dac_o=0, smp_ready_o=1, underrun_o=0 immediately.
REQ-030 SHALL cover: ORDER=1, BW=14, all inputs 0, one sample per frame -> ones count 512±1 per channel over 1024 cycles.
REQ-031 SHALL cover: ORDER=1, input +4096 -> ones count 3072±1 over 4096 cycles.
REQ-032 SHALL cover: ORDER=2, input -8191 (clamped to -6144) -> ones density 0.125±0.01 over 8192 cycles, with no integrator overflow.
REQ-033 SHALL cover: no sample supplied for one frame -> single underrun_o pulse coincident with frame_o, previous sample held, smp_ready_o stays 1.
REQ-034 SHALL cover: rst_i pulsed at cnt=30 with pend_full=1 -> pend_full=0 and frame_o first pulses OSR cycles after release.
